// File: rtl/hdb3_encoder.sv
// HDB3 line encoder: serial NRZ in, bipolar dual-rail out.
// A four-slot symbol pipeline gives room to back-patch B for a 4-zero run.
module hdb3_encoder #(
    parameter logic INIT_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    input  logic in_valid,
    output logic p_out,
    output logic n_out,
    output logic out_valid
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_V    = 2'b10,
        SYM_B    = 2'b11
    } sym_t;

    sym_t       slot_reg [4];
    logic [3:0] vld_reg;
    logic [1:0] zcnt_reg;
    logic       par_reg;
    logic       lastpol_reg;

    logic v_ins;
    sym_t sym_in;
    sym_t slot3_next;

    always_comb begin
        v_ins  = !data_in && (zcnt_reg == 2'd3);
        sym_in = data_in ? SYM_ONE : (v_ins ? SYM_V : SYM_ZERO);
        // slot2 holds the first zero of the run when the V is written
        slot3_next = (v_ins && !par_reg) ? SYM_B : slot_reg[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_reg[i] <= SYM_ZERO;
            vld_reg     <= '0;
            zcnt_reg    <= '0;
            par_reg     <= 1'b0;
            lastpol_reg <= INIT_POL;
            p_out       <= 1'b0;
            n_out       <= 1'b0;
            out_valid   <= 1'b0;
        end else if (in_valid) begin
            slot_reg[0] <= sym_in;
            slot_reg[1] <= slot_reg[0];
            slot_reg[2] <= slot_reg[1];
            slot_reg[3] <= slot3_next;
            vld_reg     <= {vld_reg[2:0], 1'b1};

            if (data_in) begin
                zcnt_reg <= 2'd0;
                par_reg  <= ~par_reg;
            end else if (v_ins) begin
                zcnt_reg <= 2'd0;
                par_reg  <= 1'b0;
            end else begin
                zcnt_reg <= zcnt_reg + 2'd1;
            end

            out_valid <= vld_reg[3];
            p_out     <= 1'b0;
            n_out     <= 1'b0;
            if (vld_reg[3]) begin
                unique case (slot_reg[3])
                    SYM_ONE, SYM_B: begin
                        p_out       <= ~lastpol_reg;
                        n_out       <= lastpol_reg;
                        lastpol_reg <= ~lastpol_reg;
                    end
                    SYM_V: begin
                        // violation repeats the previous mark polarity
                        p_out <= lastpol_reg;
                        n_out <= ~lastpol_reg;
                    end
                    default: begin
                        p_out <= 1'b0;
                        n_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdb3_encoder.sv
// Directed bench for hdb3_encoder: rails compared as {p_out,n_out},
// 2'b10 = +, 2'b01 = -, 2'b00 = 0.
module tb_hdb3_encoder;

    logic clk;
    logic rst_n;
    logic data_in;
    logic in_valid;
    logic p_out;
    logic n_out;
    logic out_valid;

    int vectors;
    int miscompares;

    logic [1:0] obs_pn [0:31];
    logic       obs_v  [0:31];

    hdb3_encoder #(.INIT_POL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .p_out     (p_out),
        .n_out     (n_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs set, posedge, sample 1 time unit later.
    task automatic step(input logic d, input logic v);
        data_in  = d;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        data_in  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enabled stream: bits[0] first, padded with ones; records outputs per edge.
    task automatic drive_seq(input logic [15:0] bits, input int len, input int total);
        for (int e = 0; e < total; e++) begin
            step((e < len) ? bits[e] : 1'b1, 1'b1);
            obs_pn[e] = {p_out, n_out};
            obs_v[e]  = out_valid;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({p_out, n_out, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 000", {p_out, n_out, out_valid});
        end
        $display("reset: p=%b n=%b v=%b", p_out, n_out, out_valid);
    endtask

    task automatic test_all_ones();
        logic [1:0] exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        drive_seq(16'b1111, 4, 8);
        for (int e = 0; e < 8; e++) begin
            vectors++;
            if (obs_v[e] !== (e >= 4)) begin
                miscompares++;
                $display("FAIL ones_valid[%0d]: got %b want %b", e, obs_v[e], (e >= 4));
            end
            if (e >= 4) begin
                vectors++;
                if (obs_pn[e] !== exp[e-4]) begin
                    miscompares++;
                    $display("FAIL ones_rail[%0d]: got %b want %b", e - 4, obs_pn[e], exp[e-4]);
                end
            end
            $display("ones edge %0d: pn=%b v=%b", e, obs_pn[e], obs_v[e]);
        end
    endtask

    task automatic test_zeros_b00v();
        logic [1:0] exp [8] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
        do_reset();
        drive_seq(16'b0000_0000, 8, 12);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs_pn[i+4] !== exp[i] || obs_v[i+4] !== 1'b1) begin
                miscompares++;
                $display("FAIL zeros_rail[%0d]: got %b/v%b want %b/v1", i, obs_pn[i+4], obs_v[i+4], exp[i]);
            end
            $display("zeros sym %0d: pn=%b", i, obs_pn[i+4]);
        end
    endtask

    task automatic test_odd_parity();
        logic [1:0] exp [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset();
        drive_seq(16'b0_0001, 5, 9);   // 1,0,0,0,0
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (obs_pn[i+4] !== exp[i]) begin
                miscompares++;
                $display("FAIL odd_rail[%0d]: got %b want %b", i, obs_pn[i+4], exp[i]);
            end
            $display("odd sym %0d: pn=%b", i, obs_pn[i+4]);
        end
    endtask

    task automatic test_even_parity();
        logic [1:0] exp [6] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
        do_reset();
        drive_seq(16'b00_0011, 6, 10); // 1,1,0,0,0,0
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (obs_pn[i+4] !== exp[i]) begin
                miscompares++;
                $display("FAIL even_rail[%0d]: got %b want %b", i, obs_pn[i+4], exp[i]);
            end
            $display("even sym %0d: pn=%b", i, obs_pn[i+4]);
        end
    endtask

    task automatic test_gap();
        logic [1:0] exp [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [4:0] bits = 5'b00001;   // 1,0,0 | gap | 0,0
        int e;
        do_reset();
        e = 0;
        for (int i = 0; i < 3; i++) step(bits[i], 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(g[0], 1'b0);
            vectors++;
            if ({p_out, n_out, out_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL gap_freeze[%0d]: got %b want 000", g, {p_out, n_out, out_valid});
            end
        end
        for (int i = 3; i < 9; i++) begin
            step((i < 5) ? bits[i] : 1'b1, 1'b1);
            if (i >= 4) begin
                vectors++;
                if ({p_out, n_out} !== exp[i-4] || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gap_rail[%0d]: got %b/v%b want %b/v1", i - 4, {p_out, n_out}, out_valid, exp[i-4]);
                end
                $display("gap sym %0d: pn=%b", i - 4, {p_out, n_out});
            end
            e++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(g[0], 1'b0);
            vectors++;
            if ({p_out, n_out, out_valid} !== 3'b101) begin
                miscompares++;
                $display("FAIL hold[%0d]: got %b want 101", g, {p_out, n_out, out_valid});
            end
            $display("hold clk %0d: pn=%b v=%b", g, {p_out, n_out}, out_valid);
        end
        step(1'b1, 1'b1);
        vectors++;
        if ({p_out, n_out, out_valid} !== 3'b011) begin
            miscompares++;
            $display("FAIL hold_resume: got %b want 011", {p_out, n_out, out_valid});
        end
    endtask

    task automatic test_async_reset_midstream();
        logic [1:0] exp [4] = '{2'b10, 2'b00, 2'b00, 2'b10};
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({p_out, n_out, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 000", {p_out, n_out, out_valid});
        end
        $display("async reset: pn=%b v=%b", {p_out, n_out}, out_valid);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_seq(16'b0000, 4, 8);
        for (int e = 0; e < 8; e++) begin
            vectors++;
            if (obs_v[e] !== (e >= 4) || (e >= 4 && obs_pn[e] !== exp[e-4])) begin
                miscompares++;
                $display("FAIL restart[%0d]: got %b/v%b want %b/v%b", e, obs_pn[e], obs_v[e],
                         (e >= 4) ? exp[e-4] : 2'b00, (e >= 4));
            end
            $display("restart edge %0d: pn=%b v=%b", e, obs_pn[e], obs_v[e]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        data_in     = 1'b0;
        in_valid    = 1'b0;
        test_reset();
        test_all_ones();
        test_zeros_b00v();
        test_odd_parity();
        test_even_parity();
        test_gap();
        test_hold();
        test_async_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
